// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  pipe_pkg
//  Shared pipeline-stage constants: occupancy encoding and MEM/WB payload layout.
//  Revision: 1.0
// ============================================================================
package pipe_pkg;

    localparam int state_w = 2;

    // Occupancy is read directly as {skid_v, main_v}.
    localparam logic [state_w-1:0] ST_EMPTY = 2'b00;
    localparam logic [state_w-1:0] ST_ONE   = 2'b01;
    localparam logic [state_w-1:0] ST_FULL  = 2'b11;

    localparam int PC_W  = 32;
    localparam int ALU_W = 32;
    localparam int RD_W  = 5;
    localparam int WE_W  = 1;
    localparam int RES_W = 32;

    localparam int RES_OFF = 0;
    localparam int WE_OFF  = RES_OFF + RES_W;
    localparam int RD_OFF  = WE_OFF + WE_W;
    localparam int ALU_OFF = RD_OFF + RD_W;
    localparam int PC_OFF  = ALU_OFF + ALU_W;

    localparam int MEMWB_W = 102;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [ALU_W-1:0] alu_out;
        logic [RD_W-1:0]  reg_dst;
        logic             reg_we;
        logic [RES_W-1:0] result;
    } memwb_t;

    function automatic logic [MEMWB_W-1:0] pack_memwb(input memwb_t f);
        logic [MEMWB_W-1:0] v;
        v                      = '0;
        v[PC_OFF  +: PC_W]     = f.pc;
        v[ALU_OFF +: ALU_W]    = f.alu_out;
        v[RD_OFF  +: RD_W]     = f.reg_dst;
        v[WE_OFF]              = f.reg_we;
        v[RES_OFF +: RES_W]    = f.result;
        return v;
    endfunction

    function automatic memwb_t unpack_memwb(input logic [MEMWB_W-1:0] v);
        memwb_t f;
        f.pc      = v[PC_OFF  +: PC_W];
        f.alu_out = v[ALU_OFF +: ALU_W];
        f.reg_dst = v[RD_OFF  +: RD_W];
        f.reg_we  = v[WE_OFF];
        f.result  = v[RES_OFF +: RES_W];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
//  pipe_skid_stage_if
//  Upstream/downstream valid-ready channel plus flush for one stage boundary.
//  Revision: 1.0
// ============================================================================
interface pipe_skid_stage_if
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_W
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_data;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  pipe_slot
//  One valid + data holding register; clear drops the valid bit only.
//  Revision: 1.0
// ============================================================================
module pipe_slot #(
    parameter int W = 102
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  pipe_skid_stage
//  Valid/ready pipeline register with flush and optional two-entry skid buffer.
//  Revision: 1.0
// ============================================================================
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_W,
    parameter int SKID      = 1
) (
    input  logic             clk,
    input  logic             rst,
    pipe_skid_stage_if.slave bus
);

    logic                 main_v;
    logic [PAYLOAD_W-1:0] main_d;
    logic                 main_load;
    logic                 main_clr;
    logic [PAYLOAD_W-1:0] main_din;
    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire       = bus.in_valid & in_ready;
    assign out_fire      = main_v & bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_d;

    pipe_slot #(.W(PAYLOAD_W)) main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clr   (main_clr),
        .d     (main_din),
        .valid (main_v),
        .q     (main_d)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic                 skid_v;
            logic [PAYLOAD_W-1:0] skid_d;
            logic                 skid_load;
            logic                 skid_clr;
            logic [state_w-1:0]   state;

            assign state    = {skid_v, main_v};
            // Registered ready: depends only on skid occupancy, never on out_ready.
            assign in_ready = ~skid_v;

            always_comb begin
                main_load = 1'b0;
                main_clr  = 1'b0;
                main_din  = bus.in_data;
                skid_load = 1'b0;
                skid_clr  = 1'b0;
                if (bus.flush) begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            main_load = in_fire;
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_load = 1'b1;
                            end else if (in_fire) begin
                                skid_load = 1'b1;
                            end else if (out_fire) begin
                                main_clr = 1'b1;
                            end
                        end
                        ST_FULL: begin
                            if (out_fire) begin
                                main_load = 1'b1;
                                main_din  = skid_d;
                                skid_clr  = 1'b1;
                            end
                        end
                        default: begin
                            // Unreachable skid-only state: promote skid into main.
                            main_load = 1'b1;
                            main_din  = skid_d;
                            skid_clr  = 1'b1;
                        end
                    endcase
                end
            end

            pipe_slot #(.W(PAYLOAD_W)) skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clr   (skid_clr),
                .d     (bus.in_data),
                .valid (skid_v),
                .q     (skid_d)
            );
        end else begin : g_single
            assign in_ready = ~main_v | bus.out_ready;

            always_comb begin
                main_din  = bus.in_data;
                main_load = in_fire & ~bus.flush;
                main_clr  = bus.flush | (out_fire & ~in_fire);
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  tb_pipe_skid_stage
//  Checks a SKID=1 and a SKID=0 instance against a queue-based occupancy model.
//  Revision: 1.0
// ============================================================================
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int W = MEMWB_W;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_skid_stage_if #(.PAYLOAD_W(W)) b1 ();
    pipe_skid_stage_if #(.PAYLOAD_W(W)) b0 ();

    pipe_skid_stage #(.PAYLOAD_W(W), .SKID(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    pipe_skid_stage #(.PAYLOAD_W(W), .SKID(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_payload();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.flush = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.in_data = '0;
        b0.flush = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b1; b0.in_data = '0;
    endtask

    task automatic test_reset();
        logic [W-1:0] ones;
        ones = '1;
        rst = 1'b1;
        b1.flush = 1'b0; b1.in_valid = 1'b1; b1.out_ready = 1'b1; b1.in_data = ones;
        b0.flush = 1'b0; b0.in_valid = 1'b1; b0.out_ready = 1'b1; b0.in_data = ones;
        repeat (3) tick();
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", b1.out_valid); end
        checks++; if (b1.out_data !== '0) begin errors++; $display("FAIL reset_data1 got %h exp 0", b1.out_data); end
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", b0.out_valid); end
        checks++; if (b0.out_data !== '0) begin errors++; $display("FAIL reset_data0 got %h exp 0", b0.out_data); end
        rst = 1'b0;
        b1.in_valid = 1'b0;
        b0.in_valid = 1'b0;
        #1;
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b exp 1", b1.in_ready); end
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", b0.in_ready); end
        tick();
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_noaccept1 got %b exp 0", b1.out_valid); end
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_noaccept0 got %b exp 0", b0.out_valid); end
    endtask

    task automatic test_stream();
        b1.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b1.in_valid = 1'b1;
            b1.in_data  = W'(i);
            tick();
            checks++;
            if (b1.out_valid !== 1'b1 || b1.out_data !== W'(i) || b1.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", i, b1.out_valid, b1.out_data, b1.in_ready, W'(i));
            end
        end
        b1.in_valid = 1'b0;
        tick();
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", b1.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, c;
        a = rand_payload(); b = rand_payload(); c = rand_payload();
        b1.in_valid = 1'b1; b1.in_data = a; b1.out_ready = 1'b1;
        tick();
        b1.in_data = b; b1.out_ready = 1'b0;
        tick();
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== a || b1.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got v=%b d=%h r=%b exp v=1 d=%h r=0", b1.out_valid, b1.out_data, b1.in_ready, a);
        end
        b1.in_data = c;
        tick();
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== a || b1.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%h r=%b exp v=1 d=%h r=0", b1.out_valid, b1.out_data, b1.in_ready, a);
        end
        b1.out_ready = 1'b1;
        tick();
        checks++;
        if (b1.out_data !== b || b1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got d=%h r=%b exp d=%h r=1", b1.out_data, b1.in_ready, b);
        end
        tick();
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== c) begin
            errors++;
            $display("FAIL bp_reaccept got v=%b d=%h exp v=1 d=%h", b1.out_valid, b1.out_data, c);
        end
        b1.in_valid = 1'b0;
        tick();
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", b1.out_valid); end
    endtask

    task automatic test_flush();
        b1.in_valid = 1'b1; b1.in_data = rand_payload(); b1.out_ready = 1'b0;
        tick();
        b1.in_data = rand_payload();
        tick();
        checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got %b exp 0", b1.in_ready); end
        b1.flush = 1'b1; b1.in_valid = 1'b1; b1.in_data = rand_payload();
        tick();
        checks++;
        if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_kill got v=%b r=%b exp v=0 r=1", b1.out_valid, b1.in_ready);
        end
        b1.flush = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_%0d got %b exp 0", i, b1.out_valid); end
        end
    endtask

    task automatic test_skid0();
        logic [W-1:0] a, d;
        a = rand_payload();
        b0.in_valid = 1'b1; b0.in_data = a; b0.out_ready = 1'b0;
        #1;
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_ready got %b exp 1", b0.in_ready); end
        tick();
        checks++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== a || b0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL s0_stall got v=%b d=%h r=%b exp v=1 d=%h r=0", b0.out_valid, b0.out_data, b0.in_ready, a);
        end
        for (int i = 0; i < 4; i++) begin
            d = rand_payload();
            b0.in_data = d; b0.out_ready = 1'b1;
            #1;
            checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb_ready_%0d got %b exp 1", i, b0.in_ready); end
            tick();
            checks++;
            if (b0.out_valid !== 1'b1 || b0.out_data !== d) begin
                errors++;
                $display("FAIL s0_replace_%0d got v=%b d=%h exp v=1 d=%h", i, b0.out_valid, b0.out_data, d);
            end
        end
        b0.in_valid = 1'b0;
        tick();
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL s0_empty got %b exp 0", b0.out_valid); end
    endtask

    task automatic test_random();
        logic [W-1:0] q1[$];
        logic [W-1:0] q0[$];
        logic         er1, ev1, er0, ev0, if1, of1, if0, of0, fl1, fl0, rs;
        logic [W-1:0] d1, d0;
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rs           = ($urandom_range(0, 511) == 0);
            rst          = rs;
            b1.flush     = ($urandom_range(0, 31) == 0);
            b1.in_valid  = $urandom_range(0, 1) != 0;
            b1.out_ready = $urandom_range(0, 3) != 0;
            b1.in_data   = rand_payload();
            b0.flush     = ($urandom_range(0, 31) == 0);
            b0.in_valid  = $urandom_range(0, 1) != 0;
            b0.out_ready = $urandom_range(0, 3) != 0;
            b0.in_data   = rand_payload();
            #1;
            er1 = (q1.size() < 2);
            ev1 = (q1.size() != 0);
            er0 = (q0.size() == 0) || b0.out_ready;
            ev0 = (q0.size() != 0);
            checks++; if (b1.in_ready !== er1) begin errors++; $display("FAIL rnd_ready1 cyc %0d got %b exp %b", cyc, b1.in_ready, er1); end
            checks++; if (b1.out_valid !== ev1) begin errors++; $display("FAIL rnd_valid1 cyc %0d got %b exp %b", cyc, b1.out_valid, ev1); end
            if (ev1) begin
                checks++; if (b1.out_data !== q1[0]) begin errors++; $display("FAIL rnd_data1 cyc %0d got %h exp %h", cyc, b1.out_data, q1[0]); end
            end
            checks++; if (b0.in_ready !== er0) begin errors++; $display("FAIL rnd_ready0 cyc %0d got %b exp %b", cyc, b0.in_ready, er0); end
            checks++; if (b0.out_valid !== ev0) begin errors++; $display("FAIL rnd_valid0 cyc %0d got %b exp %b", cyc, b0.out_valid, ev0); end
            if (ev0) begin
                checks++; if (b0.out_data !== q0[0]) begin errors++; $display("FAIL rnd_data0 cyc %0d got %h exp %h", cyc, b0.out_data, q0[0]); end
            end
            if1 = b1.in_valid & er1;  of1 = ev1 & b1.out_ready;  fl1 = b1.flush;  d1 = b1.in_data;
            if0 = b0.in_valid & er0;  of0 = ev0 & b0.out_ready;  fl0 = b0.flush;  d0 = b0.in_data;
            tick();
            if (rs || fl1) q1.delete();
            else begin
                if (of1) void'(q1.pop_front());
                if (if1) q1.push_back(d1);
            end
            if (rs || fl0) q0.delete();
            else begin
                if (of0) void'(q0.pop_front());
                if (if0) q0.push_back(d0);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        idle_inputs();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generic successor to the fixed-field, stall-driven inter-stage registers (IF/ID … MEM/WB). Any stage boundary carries its payload as one packed vector through this block. Upstream stalls are replaced by backpressure, and in skid mode `in_ready` is registered, which breaks the long stall path across the pipeline.

## Interface
- `PAYLOAD_W`, 102 — packed payload width (MEM/WB default: pc 32 + alu_out 32 + reg_dst 5 + reg_we 1 + result 32).
- `SKID`, 1 — 1: two-entry skid buffer with registered `in_ready`; 0: single register with combinational `in_ready`.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `flush`  in  1  synchronous kill of every held entry.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  `PAYLOAD_W`  upstream payload.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `PAYLOAD_W`  payload to downstream.

## Operation
- Handshake events:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
- Storage:
  - `main` register (`main_v`, `main_d`) drives `out_valid`/`out_data`.
  - `skid` register (`skid_v`, `skid_d`) exists only when `SKID=1`.
- SKID=1 state machine:
  - EMPTY (`main_v=0`, `skid_v=0`): `in_fire` -> ONE, and `main_d` is loaded with `in_data`.
  - ONE (`main_v=1`, `skid_v=0`):
    - `in_fire & out_fire` -> ONE, `main_d` loaded with `in_data`.
    - `in_fire & ~out_ready` -> FULL, `skid_d` loaded with `in_data`.
    - `~in_fire & out_fire` -> EMPTY.
    - Otherwise hold.
  - FULL (`main_v=1`, `skid_v=1`): `out_fire` -> ONE, `main_d` loaded with `skid_d`. Otherwise hold.
  - `in_ready = ~skid_v`, a registered value. In FULL the stage deasserts `in_ready` and never accepts input.
- SKID=0:
  - `in_ready = ~main_v | out_ready`, combinational.
  - `in_fire` loads `main_d` and sets `main_v`.
  - `out_fire` without `in_fire` clears `main_v`.
- Flush:
  - On the next edge, `main_v` and `skid_v` are cleared.
  - An `in_fire` in the same cycle is discarded.
  - Data registers are not cleared.
- Priority: `rst` > `flush` > handshake.
- Stability: while `out_valid & ~out_ready`, `out_data` and `out_valid` stay constant (AXI-style). `in_data` is not required to hold while `in_ready=0`.
- Ordering: payloads leave in acceptance order. None are dropped or duplicated except when killed by `flush`.

## Timing
- Reset values:
  - `out_valid` = 0.
  - `out_data` = 0.
  - `main_d` and `skid_d` = 0.
  - `in_ready` = 1 in the first cycle after reset deasserts; with `SKID=0` it is 1 while `main_v=0`.
- Latency: an `in_fire` at edge N gives `out_valid` = 1 after edge N (1 cycle) when the stage was EMPTY.
- Throughput: 1 payload per cycle sustained while `out_ready=1`.
- SKID=1 backpressure:
  - Dropping `out_ready` costs at most one extra accepted payload, which goes into skid.
  - `in_ready` falls the cycle after FULL is entered.
  - `in_ready` rises the cycle after the FULL -> ONE drain.
- Flush: the cycle after `flush` is high, `out_valid` = 0 and `in_ready` = 1.
- Reset mid-operation: all entries are lost, outputs go to reset values at the next edge, and no partial payload appears.
- Combinational paths:
  - SKID=1: none from inputs to outputs.
  - SKID=0: `out_ready` -> `in_ready` only.

## Structure
- Shared package `pipe_pkg`:
  - State localparams `ST_EMPTY`, `ST_ONE`, `ST_FULL`, plus `state_w`.
  - MEM/WB field widths and offsets (`PC_OFF`, `ALU_OFF`, `RD_OFF`, `WE_OFF`, `RES_OFF`).
  - `MEMWB_W = 102`.
  - Pack/unpack functions.
- One sub-module, `pipe_slot`: a single valid + data register with load, clear and reset. It is instantiated as `main` and, under `generate if (SKID)`, as `skid`.
- State is derived from `{skid_v, main_v}`; there is no separate state register.

## Test plan
- Reset: assert `rst` for 3 cycles while `in_valid=1`, `in_data=0x3FF…F` -> `out_valid=0`, `out_data=0`, `in_ready=1` on release, nothing accepted.
- Streaming: SKID=1, `out_ready=1`, inputs 1,2,3,4 on consecutive cycles -> outputs 1,2,3,4 on the next 4 cycles, 1-cycle latency, no bubbles.
- Backpressure:
  - SKID=1, `out_ready=0` from cycle 2, inputs A,B,C -> A held on output, B captured in skid, `in_ready=0`, C not accepted.
  - `out_ready=1` -> A, then B, then C after re-acceptance.
- Flush in FULL: state FULL (A main, B skid), `flush=1` with `in_valid=1`, data D -> next cycle `out_valid=0`, `in_ready=1`, and A, B, D never appear.
- SKID=0: `out_ready=0` with `main_v=1` -> `in_ready=0` in the same cycle. `out_ready=1` with `in_valid=1` -> replacement accepted in the same cycle, throughput 1/cycle.
- Random: random `in_valid`/`out_ready`/`flush` for 10k cycles against a scoreboard queue -> order preserved, no loss except flushed entries, output stable while stalled.
